// File: rtl/fperm_lanes.sv
// fperm_lanes: N-lane FP permute unit with shuffle/blend and per-lane reciprocal and
// rsqrt exponent-seed estimates, behind an LAT-deep pipeline that supports stall and flush.
// The result bus is released (z) or zeroed while no valid result is presented.

`ifdef swapedge
`define FPERM_EDGE posedge
`else
`define FPERM_EDGE negedge
`endif

module fperm_lanes #(
    parameter int unsigned LANES    = 2,
    parameter int unsigned LANEW    = 33,
    parameter int unsigned EXPW     = 9,
    parameter int unsigned BIAS     = 255,
    parameter int unsigned LAT      = 1,
    parameter int unsigned TRISTATE = 1,
    localparam int unsigned W       = LANES * LANEW + 2,
    localparam int unsigned IDXW    = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             stall,
    input  logic             flush,
    input  logic [2:0]       op,
    input  logic             srcA,
    input  logic [IDXW-1:0]  idx,
    input  logic [LANES-1:0] mask,
    input  logic [W-1:0]     A,
    input  logic [W-1:0]     B,
    output logic [W-1:0]     res,
    output logic             res_valid
);

    localparam logic [2:0] OpPass  = 3'd0;
    localparam logic [2:0] OpSwap  = 3'd1;
    localparam logic [2:0] OpBcast = 3'd2;
    localparam logic [2:0] OpRev   = 3'd3;
    localparam logic [2:0] OpRecip = 3'd4;
    localparam logic [2:0] OpRsqrt = 3'd5;
    localparam logic [2:0] OpBlend = 3'd6;

    localparam logic [EXPW-1:0] BiasE = EXPW'(BIAS);
    // Sign/mantissa-top bit kept from the source lane in the seed estimates.
    localparam int unsigned KeepBit = LANEW - EXPW - 1;

    logic [LANEW-1:0] a_lane [LANES];
    logic [LANEW-1:0] b_lane [LANES];
    logic [LANEW-1:0] s_lane [LANES];
    logic [LANEW-1:0] r_lane [LANES];
    logic [1:0]       a_tag;
    logic [1:0]       b_tag;
    logic [1:0]       s_tag;
    logic [1:0]       r_tag;
    logic [W-1:0]     comb_res;

    logic [W-1:0]     data_q [LAT];
    logic [LAT-1:0]   valid_q;

    // Split both operands into lanes and pick the single-source operand.
    always_comb begin
        a_tag = A[W-1 -: 2];
        b_tag = B[W-1 -: 2];
        s_tag = srcA ? a_tag : b_tag;
        for (int i = 0; i < int'(LANES); i++) begin
            a_lane[i] = A[i*LANEW +: LANEW];
            b_lane[i] = B[i*LANEW +: LANEW];
            s_lane[i] = srcA ? a_lane[i] : b_lane[i];
        end
    end

    // Per-lane operation decode; op7 and any unused code fall back to pass-through.
    always_comb begin
        int unsigned     partner;
        int unsigned     sel;
        logic [EXPW-1:0] exp_in;
        logic [EXPW-1:0] exp_src;
        logic [EXPW-1:0] exp_out;

        partner = 0;
        sel     = 0;
        exp_in  = '0;
        exp_src = '0;
        exp_out = '0;
        r_tag   = s_tag;
        for (int i = 0; i < int'(LANES); i++) begin
            r_lane[i] = s_lane[i];
        end

        case (op)
            OpPass: begin
                r_tag = s_tag;
            end
            OpSwap: begin
                for (int i = 0; i < int'(LANES); i++) begin
                    // The unpaired last lane of an odd lane count stays in place.
                    partner = ((i ^ 1) < int'(LANES)) ? (i ^ 1) : i;
                    r_lane[i] = s_lane[partner];
                end
            end
            OpBcast: begin
                sel = (32'(idx) < LANES) ? 32'(idx) : 0;
                for (int i = 0; i < int'(LANES); i++) begin
                    r_lane[i] = s_lane[sel];
                end
            end
            OpRev: begin
                for (int i = 0; i < int'(LANES); i++) begin
                    r_lane[i] = s_lane[int'(LANES) - 1 - i];
                end
            end
            OpRecip, OpRsqrt: begin
                r_tag = b_tag;
                for (int i = 0; i < int'(LANES); i++) begin
                    exp_in  = b_lane[i][LANEW-1 -: EXPW];
                    exp_src = (op == OpRsqrt) ? (exp_in >> 1) : exp_in;
                    // Wraps modulo 2^EXPW by construction of the field width.
                    exp_out = BiasE - exp_src;
                    r_lane[i] = '0;
                    r_lane[i][LANEW-1 -: EXPW] = exp_out;
                    r_lane[i][KeepBit] = b_lane[i][KeepBit];
                end
            end
            OpBlend: begin
                r_tag = a_tag;
                for (int i = 0; i < int'(LANES); i++) begin
                    r_lane[i] = mask[i] ? a_lane[i] : b_lane[i];
                end
            end
            default: begin
                r_tag = s_tag;
            end
        endcase
    end

    // Reassemble the lanes and the type tag into one bus word.
    always_comb begin
        comb_res = '0;
        comb_res[W-1 -: 2] = r_tag;
        for (int i = 0; i < int'(LANES); i++) begin
            comb_res[i*LANEW +: LANEW] = r_lane[i];
        end
    end

    // Valid shift register: reset and flush clear it, stall freezes it.
    always_ff @(`FPERM_EDGE clk) begin
        if (rst || flush) begin
            valid_q <= '0;
        end else if (!stall) begin
            valid_q[0] <= en;
            for (int s = 1; s < int'(LANT_GUARD(LAT)); s++) begin
                valid_q[s] <= valid_q[s-1];
            end
        end
    end

    // Data shift register has no reset; its contents only matter where valid is set.
    always_ff @(`FPERM_EDGE clk) begin
        if (!stall) begin
            data_q[0] <= comb_res;
            for (int s = 1; s < int'(LAT); s++) begin
                data_q[s] <= data_q[s-1];
            end
        end
    end

    function automatic int unsigned LANT_GUARD(input int unsigned depth);
        return depth;
    endfunction

    assign res_valid = valid_q[LAT-1];

    // Bus driver: released or zeroed whenever the last stage holds no valid result.
    generate
        if (TRISTATE != 0) begin : g_tri
            assign res = res_valid ? data_q[LAT-1] : {W{1'bz}};
        end else begin : g_zero
            assign res = res_valid ? data_q[LAT-1] : '0;
        end
    endgenerate

endmodule

`undef FPERM_EDGE

// File: doc/fperm_lanes.md
Name: fperm_lanes

Overview:
- Parametrised successor to the FP permute unit: N-lane shuffle/blend plus per-lane reciprocal and rsqrt exponent-seed estimate.
- Configurable pipeline depth, with valid tracking, stall and flush.
- Sits in the FP execution cluster and drives the shared result bus; undriven (z) when idle if TRISTATE=1.

Parameters:
- LANES, 2, number of single lanes per operand (1..8).
- LANEW, 33, bits per lane.
- EXPW, 9, exponent field width; occupies lane bits [LANEW-1:LANEW-EXPW].
- BIAS, 255, exponent bias, EXPW bits.
- LAT, 1, pipeline depth in clock edges (1..4).
- TRISTATE, 1, 1: res is z when not valid; 0: res is 0 when not valid.
- Derived: W = LANES*LANEW+2. Lane i = bits [i*LANEW+LANEW-1 : i*LANEW]. Type tag = [W-1:W-2].

Ports:
- clk  in  1  clock; registers update on negedge, or posedge when swapedge is defined.
- rst  in  1  synchronous, active-high reset.
- en  in  1  issue valid.
- stall  in  1  freeze pipeline.
- flush  in  1  kill in-flight ops.
- op  in  3  operation code.
- srcA  in  1  source select for single-source ops (1=A, 0=B).
- idx  in  max(1,clog2(LANES))  broadcast lane index.
- mask  in  LANES  blend mask.
- A  in  W  operand A.
- B  in  W  operand B.
- res  out  W  result bus.
- res_valid  out  1  result qualifier.

Behaviour:
- S denotes A if srcA else B. Output tag = S tag for ops 0-3 and 7; B tag for ops 4-5; A tag for op 6.
- op0 PASS: res = S.
- op1 SWAP: lane 2k <-> lane 2k+1. With odd LANES, the last lane is unchanged.
- op2 BCAST: every lane = S lane idx. If idx >= LANES, use lane 0.
- op3 REV: lane i = S lane LANES-1-i.
- op4 RECIP: per lane of B, exp' = (BIAS - E) mod 2^EXPW.
- op5 RSQRT: per lane of B, exp' = (BIAS - (E>>1)) mod 2^EXPW.
- ops 4-5 lane output: {exp', B lane bit [LANEW-EXPW-1], zeros}.
- op6 BLEND: lane i = mask[i] ? A lane i : B lane i.
- op7: treated as PASS.
- Pipeline: the combinational result is captured in stage 1 when en is sampled. The data/valid shift register is LAT deep.
- res/res_valid present stage LAT. Latency = LAT edges: with LAT=1, the result is visible after the first capturing edge.
- stall=1: all stages and valids hold, and en is ignored (not captured). res keeps driving the held stage LAT.
- flush=1: all valid bits cleared on that edge. A new en on the same edge is also dropped. flush overrides stall.
- rst=1: all valid bits cleared; res_valid=0 and res=z (TRISTATE=1) or 0. Data regs need not reset. rst mid-pipeline discards all in-flight ops; the first en after rst deasserts behaves as from idle.
- Back-to-back en each edge yields one result per edge, in order, without bubbles.
- Simultaneous rst/flush/stall: rst > flush > stall.
- res and res_valid are derived only from registered state, with no combinational path from inputs.

Test Plan:
- LANES=2, LAT=1: op1, srcA=1, A={2'b01, lane1=33'h1_0000_0001, lane0=33'h0_0000_0002} -> one edge later res={2'b01, 33'h0_0000_0002, 33'h1_0000_0001}, res_valid=1; next edge res=z, res_valid=0.
- op4, B lane0 exp=9'd100, lane1 exp=9'd255 with bit23=1 -> lane0 exp 155 and mantissa 0; lane1 exp 0 and bit23=1. op5 with lane0 exp=100 -> exp 205.
- LANES=4, op2, idx=2, srcA=0 -> all four lanes equal B lane 2. op3 -> lanes reversed. op6, mask=4'b0101 -> lanes 0 and 2 from A, lanes 1 and 3 from B.
- LAT=3: issue 4 ops on consecutive edges, stall high on edge 2 for one cycle -> results emerge in order. Latency is 3 edges, plus 1 for ops in flight during the stall; no duplicates or losses.
- LAT=3: issue 2 ops, flush on the next edge with en=1 -> res_valid stays 0 for 3 edges. An op issued after the flush emerges normally.
- rst asserted with 2 ops in flight -> res_valid=0 immediately after the edge; tristate z observed. TRISTATE=0 build -> res=0 when idle.
